// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a bounded hold time.
// Grants are registered and presented both as a binary index and as the
// matching one-hot vector. A rotating pointer gives fair ordering. A hold
// counter forces a hand-over when an owner keeps the resource while others wait.
module rr_arbiter_4 #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Hold count at which a contended owner must give up the grant.
    localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD - 1);

    state_t      state_reg;
    logic [1:0]  ptr_reg;
    logic [3:0]  hold_cnt_reg;

    // Scan order: from ptr when idle, from the owner's successor when busy.
    logic [1:0]  scan_base;
    logic [1:0]  scan_idx [4];
    logic [3:0]  scan_hit;
    logic        win_found;
    logic [1:0]  win_idx;
    logic        owner_req;

    // Select where the priority scan starts.
    always_comb begin
        scan_base = (state_reg == BUSY) ? (gnt_idx + 2'd1) : ptr_reg;
    end

    // One scan slot per rotation step. While busy, the current owner is
    // never a candidate. When the owner releases, its request bit is already
    // low. When it is forced out, it must not win again.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_scan
            assign scan_idx[gi] = scan_base + 2'(gi);
            assign scan_hit[gi] = req[scan_idx[gi]] &&
                                  !((state_reg == BUSY) && (scan_idx[gi] == gnt_idx));
        end
    endgenerate

    // Pick the first hit in scan order. Iterate downward so the lowest slot wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = scan_base;
        for (int i = 3; i >= 0; i--) begin
            if (scan_hit[i]) begin
                win_found = 1'b1;
                win_idx   = scan_idx[i];
            end
        end
    end

    // Record whether the current owner is still requesting.
    always_comb begin
        owner_req = req[gnt_idx];
    end

    // Arbitration state machine with registered grant outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            ptr_reg      <= 2'd0;
            hold_cnt_reg <= 4'd0;
            gnt          <= 4'b0000;
            gnt_idx      <= 2'b00;
            gnt_valid    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (win_found) begin
                        state_reg    <= BUSY;
                        gnt_idx      <= win_idx;
                        gnt          <= 4'b0001 << win_idx;
                        gnt_valid    <= 1'b1;
                        hold_cnt_reg <= 4'd0;
                    end
                end
                BUSY: begin
                    if (!owner_req) begin
                        // Release: move priority past the owner and hand over
                        // with no idle cycle if anyone else is waiting.
                        ptr_reg <= gnt_idx + 2'd1;
                        if (win_found) begin
                            gnt_idx      <= win_idx;
                            gnt          <= 4'b0001 << win_idx;
                            hold_cnt_reg <= 4'd0;
                        end else begin
                            state_reg    <= IDLE;
                            gnt          <= 4'b0000;
                            gnt_valid    <= 1'b0;
                            hold_cnt_reg <= 4'd0;
                        end
                    end else if (!win_found || (hold_cnt_reg < HOLD_LIMIT)) begin
                        // Keep the grant. The counter saturates so that a long
                        // uncontended run hands over as soon as contention appears.
                        if (hold_cnt_reg != 4'hF) begin
                            hold_cnt_reg <= hold_cnt_reg + 4'd1;
                        end
                    end else begin
                        // Forced hand-over after the maximum contended hold.
                        ptr_reg      <= gnt_idx + 2'd1;
                        gnt_idx      <= win_idx;
                        gnt          <= 4'b0001 << win_idx;
                        hold_cnt_reg <= 4'd0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    gnt       <= 4'b0000;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed and random checks for rr_arbiter_4 against a behavioural model
// of the round-robin rules: who owns the resource, for how long, and who is next.
module tb_rr_arbiter_4;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state (plain integers)
    bit m_valid = 0;
    int m_owner = 0;
    int m_ptr   = 0;
    int m_hold  = 0;

    int stale_cycles = 0;

    rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always #5 clk = ~clk;

    // First requester at or after 'start' (mod 4), skipping 'excl'; -1 if none.
    function automatic int pick(int start, logic [3:0] r, int excl);
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (start + k) % 4;
            if (idx != excl && r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_owner = 0; m_ptr = 0; m_hold = 0;
    endtask

    task automatic model_edge(input logic [3:0] r);
        int w;
        if (!m_valid) begin
            w = pick(m_ptr, r, -1);
            if (w >= 0) begin m_valid = 1; m_owner = w; m_hold = 0; end
        end else if (!r[m_owner]) begin
            m_ptr = (m_owner + 1) % 4;
            w = pick(m_ptr, r, m_owner);
            m_hold = 0;
            if (w >= 0) m_owner = w;
            else m_valid = 0;
        end else begin
            bit others;
            others = (r & ~(4'b0001 << m_owner)) != 4'b0000;
            if (others && m_hold >= MAX_HOLD - 1) begin
                m_ptr = (m_owner + 1) % 4;
                m_owner = pick(m_ptr, r, m_owner);
                m_hold = 0;
            end else if (m_hold < 15) begin
                m_hold = m_hold + 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [3:0] exp_gnt;
        exp_gnt = m_valid ? (4'b0001 << m_owner) : 4'b0000;
        chk({tag, "_gnt"}, gnt, exp_gnt);
        chk({tag, "_valid"}, {3'b000, gnt_valid}, {3'b000, m_valid});
        if (m_valid) chk({tag, "_idx"}, {2'b00, gnt_idx}, 4'(m_owner));
    endtask

    // One clock: drive req (already at the negedge), advance the model at the
    // posedge, check #1 later, and return at the next negedge.
    task automatic cycle(input logic [3:0] r, input string tag);
        req = r;
        @(posedge clk);
        model_edge(r);
        #1;
        check_model(tag);
        $display("%0t %s req=%b gnt=%b idx=%0d valid=%b", $time, tag, r, gnt, gnt_idx, gnt_valid);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req = 4'b0000;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] r;

        // Reset state while held in reset
        #3;
        chk("rst_hold_gnt", gnt, 4'b0000);
        chk("rst_hold_valid", {3'b000, gnt_valid}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Reset pulse during a grant: outputs must clear immediately
        cycle(4'b1111, "pre_rst");
        cycle(4'b1111, "pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_gnt", gnt, 4'b0000);
        chk("async_rst_idx", {2'b00, gnt_idx}, 4'b0000);
        chk("async_rst_valid", {3'b000, gnt_valid}, 4'b0000);
        #1;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        cycle(4'b1111, "post_rst");
        chk("post_rst_first", gnt, 4'b0001);

        // Single requester: held without preemption, cleared after the drop
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(4'b0100, "single");
            chk("single_const", gnt, 4'b0100);
        end
        cycle(4'b0000, "single_drop");
        chk("single_drop_const", gnt, 4'b0000);

        // Rotation: each owner releases after one cycle
        do_reset();
        begin
            logic [3:0] exp_seq [5];
            exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
            exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
            for (int i = 0; i < 5; i++) begin
                cycle(4'b1111 & ~gnt, "rotate");
                chk("rotate_seq", gnt, exp_seq[i]);
            end
        end

        // Forced hand-over with two constant requesters
        do_reset();
        for (int i = 0; i < 12; i++) begin
            cycle(4'b0011, "forced");
            chk("forced_seq", gnt, ((i / MAX_HOLD) % 2 == 0) ? 4'b0001 : 4'b0010);
        end

        // Pointer fairness after owner 2 releases
        do_reset();
        cycle(4'b0100, "fair");
        chk("fair_own2", gnt, 4'b0100);
        cycle(4'b1011, "fair");
        chk("fair_next3", gnt, 4'b1000);
        cycle(4'b0011, "fair");
        chk("fair_next0", gnt, 4'b0001);
        cycle(4'b0010, "fair");
        chk("fair_next1", gnt, 4'b0010);

        // Saturated hold count: immediate hand-over once contention appears
        do_reset();
        for (int i = 0; i < 20; i++) cycle(4'b0001, "sat");
        cycle(4'b0011, "sat_contend");
        chk("sat_handover", gnt, 4'b0010);

        // Random traffic: model comparison and stale-grant bound
        do_reset();
        r = 4'b0000;
        for (int i = 0; i < 1000; i++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
            end
            cycle(r, "rand");
            if (gnt_valid && !req[gnt_idx]) stale_cycles++;
            else stale_cycles = 0;
            n_assert++;
            assert (stale_cycles <= 1) else begin
                n_fail++;
                $error("FAIL stale_grant observed=%0d cycles expected<=1", stale_cycles);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
